seq_detect_param: RTL and testbench

Parametrised Moore-style sequence detector, successor to the fixed 2-bit/4-state detector FSMs in the HW5 series. Watches a stream of W-bit symbols qualified by a valid strobe and matches the last DEPTH accepted symbols against a run-time loadable pattern. Reports a registered match pulse, a saturating match counter and the current fill state. Overlapping or non-overlapping detection is chosen by parameter.

---
 rtl/seq_detect_param.sv | 129 ++++++++++++
 tb/tb_seq_detect_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised Moore sequence detector: matches the last DEPTH accepted W-bit symbols
// against a loadable pattern. Optional STICKY_OUT_EN adds a sticky match flag (out_sticky).
module seq_detect_param #(
  parameter int W       = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1,
  parameter logic [W*DEPTH-1:0] RESET_PAT = '0
) (
  input  logic                       clock,
  input  logic                       init,
  input  logic                       in_valid,
  input  logic [W-1:0]               in,
  input  logic                       pat_load,
  input  logic [W*DEPTH-1:0]         pat_in,
  input  logic                       clear,
  output logic                       out,
`ifdef STICKY_OUT_EN
  output logic                       out_sticky,
`endif
  output logic [CNT_W-1:0]           match_count,
  output logic [$clog2(DEPTH+1)-1:0] state
);

  localparam int SW = $clog2(DEPTH + 1);
  localparam logic [SW-1:0]    DEPTH_S = SW'(DEPTH);
  localparam logic [SW-1:0]    ONE_S   = SW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // History symbol k lives in bits [k*W +: W]; slot 0 is the oldest, so a full
  // history lines up directly with pattern symbol 0..DEPTH-1.
  logic [W*DEPTH-1:0] pattern_r;
  logic [W*DEPTH-1:0] hist_r;
  logic [W*DEPTH-1:0] pattern_n_s;
  logic [W*DEPTH-1:0] hist_n_s;
  logic [W*DEPTH-1:0] shifted_s;
  logic [SW-1:0]      fill_inc_s;
  logic [SW-1:0]      fill_n_s;
  logic               match_s;
  logic               out_n_s;
  logic [CNT_W-1:0]   cnt_n_s;
`ifdef STICKY_OUT_EN
  logic               sticky_n_s;
`endif

  // State register: pattern, history, fill level and registered outputs
  always_ff @(posedge clock or negedge init) begin
    if (!init) begin
      pattern_r   <= RESET_PAT;
      hist_r      <= '0;
      state       <= '0;
      out         <= 1'b0;
      match_count <= '0;
`ifdef STICKY_OUT_EN
      out_sticky  <= 1'b0;
`endif
    end else begin
      pattern_r   <= pattern_n_s;
      hist_r      <= hist_n_s;
      state       <= fill_n_s;
      out         <= out_n_s;
      match_count <= cnt_n_s;
`ifdef STICKY_OUT_EN
      out_sticky  <= sticky_n_s;
`endif
    end
  end

  // Next-state logic: load > clear > accepted symbol; a match only counts on a full history
  always_comb begin
    pattern_n_s = pattern_r;
    hist_n_s    = hist_r;
    fill_n_s    = state;
    match_s     = 1'b0;
    shifted_s   = {in, hist_r[W*DEPTH-1:W]};
    fill_inc_s  = (state == DEPTH_S) ? state : state + ONE_S;
    if (pat_load) begin
      pattern_n_s = pat_in;
      hist_n_s    = '0;
      fill_n_s    = '0;
    end else if (clear) begin
      hist_n_s = '0;
      fill_n_s = '0;
    end else if (in_valid) begin
      hist_n_s = shifted_s;
      fill_n_s = fill_inc_s;
      match_s  = (fill_inc_s == DEPTH_S) && (shifted_s == pattern_r);
      if (match_s && (OVERLAP == 0)) begin
        hist_n_s = '0;
        fill_n_s = '0;
      end else begin
        hist_n_s = shifted_s;
      end
    end else begin
      hist_n_s = hist_r;
    end
  end

  // Output logic: single-cycle match pulse and saturating counter
  always_comb begin
    out_n_s = match_s;
    cnt_n_s = match_count;
    if (pat_load) begin
      cnt_n_s = match_count;
    end else if (clear) begin
      cnt_n_s = '0;
    end else if (match_s && (match_count != CNT_MAX)) begin
      cnt_n_s = match_count + CNT_ONE;
    end else begin
      cnt_n_s = match_count;
    end
  end

`ifdef STICKY_OUT_EN
  // Sticky flag: set by any match, dropped only by load, clear or reset
  always_comb begin
    sticky_n_s = out_sticky;
    if (pat_load || clear) begin
      sticky_n_s = 1'b0;
    end else if (match_s) begin
      sticky_n_s = 1'b1;
    end else begin
      sticky_n_s = out_sticky;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: three configurations driven by one stream,
// checked against an array-based model of the detection rules.
module tb_seq_detect_param;

  logic       clock = 1'b0;
  logic       init = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in = 2'b00;
  logic       pat_load = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] pat0 = 6'd0;
  logic [3:0] pat1 = 4'd0;
  logic [3:0] pat2 = 4'd0;

  logic       o0, o1, o2;
  logic [7:0] c0;
  logic [1:0] c1;
  logic [7:0] c2;
  logic [1:0] s0, s1, s2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  seq_detect_param #(.W(2), .DEPTH(3), .CNT_W(8), .OVERLAP(1)) u0 (
    .clock(clock), .init(init), .in_valid(in_valid), .in(in), .pat_load(pat_load),
    .pat_in(pat0), .clear(clear), .out(o0), .match_count(c0), .state(s0));
  seq_detect_param #(.W(2), .DEPTH(2), .CNT_W(2), .OVERLAP(0)) u1 (
    .clock(clock), .init(init), .in_valid(in_valid), .in(in), .pat_load(pat_load),
    .pat_in(pat1), .clear(clear), .out(o1), .match_count(c1), .state(s1));
  seq_detect_param #(.W(2), .DEPTH(2), .CNT_W(8), .OVERLAP(1)) u2 (
    .clock(clock), .init(init), .in_valid(in_valid), .in(in), .pat_load(pat_load),
    .pat_in(pat2), .clear(clear), .out(o2), .match_count(c2), .state(s2));

  // Reference model: per instance, a list of accepted symbols and a match counter
  int dep[3]  = '{3, 2, 2};
  int cmax[3] = '{255, 3, 255};
  int ovl[3]  = '{1, 0, 1};
  int pat[3][3];
  int hist[3][3];
  int fill[3];
  int cnt[3];

  typedef struct packed {
    logic [2:0]      o;
    logic [2:0][7:0] c;
    logic [2:0][7:0] s;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      fill[i] = 0;
      cnt[i]  = 0;
      for (int k = 0; k < 3; k++) begin
        pat[i][k]  = 0;
        hist[i][k] = 0;
      end
    end
  endtask

  // Drive one edge's inputs, predict the outcome, and hand it to the monitor after the edge
  task automatic step(input logic pl, input logic [5:0] p0, input logic [3:0] p1,
                      input logic [3:0] p2, input logic clr, input logic v, input logic [1:0] sym);
    exp_t e;
    logic [5:0] pv;
    bit m;
    @(negedge clock);
    #1;
    pat_load = pl; pat0 = p0; pat1 = p1; pat2 = p2;
    clear = clr; in_valid = v; in = sym;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      m = 1'b0;
      pv = (i == 0) ? p0 : ((i == 1) ? {2'b00, p1} : {2'b00, p2});
      if (pl) begin
        for (int k = 0; k < dep[i]; k++) pat[i][k] = int'((pv >> (2 * k)) & 6'd3);
        fill[i] = 0;
      end else if (clr) begin
        fill[i] = 0;
        cnt[i]  = 0;
      end else if (v) begin
        if (fill[i] == dep[i]) begin
          for (int k = 0; k < dep[i] - 1; k++) hist[i][k] = hist[i][k+1];
          hist[i][dep[i]-1] = int'(sym);
        end else begin
          hist[i][fill[i]] = int'(sym);
          fill[i]++;
        end
        if (fill[i] == dep[i]) begin
          m = 1'b1;
          for (int k = 0; k < dep[i]; k++) if (hist[i][k] != pat[i][k]) m = 1'b0;
        end
        if (m) begin
          if (cnt[i] < cmax[i]) cnt[i]++;
          if (ovl[i] == 0) fill[i] = 0;
        end
      end
      e.o[i] = m;
      e.c[i] = 8'(cnt[i]);
      e.s[i] = 8'(fill[i]);
    end
    @(posedge clock);
    sb.push_back(e);
  endtask

  task automatic feed(input logic [1:0] sym);
    step(1'b0, pat0, pat1, pat2, 1'b0, 1'b1, sym);
  endtask

  task automatic idle();
    step(1'b0, pat0, pat1, pat2, 1'b0, 1'b0, 2'b00);
  endtask

  // Monitor: every falling edge, compare the outputs of the last predicted edge
  always @(negedge clock) begin
    exp_t e;
    logic       ao[3];
    logic [7:0] ac[3];
    logic [7:0] as[3];
    if (sb.size() > 0) begin
      e = sb.pop_front();
      ao = '{o0, o1, o2};
      ac = '{c0, {6'd0, c1}, c2};
      as = '{{6'd0, s0}, {6'd0, s1}, {6'd0, s2}};
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.out", i), 32'(ao[i]), 32'(e.o[i]));
        chk($sformatf("u%0d.match_count", i), 32'(ac[i]), 32'(e.c[i]));
        chk($sformatf("u%0d.state", i), 32'(as[i]), 32'(e.s[i]));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " u0.out"}, 32'(o0), 32'd0);
    chk({tag, " u1.out"}, 32'(o1), 32'd0);
    chk({tag, " u2.out"}, 32'(o2), 32'd0);
    chk({tag, " u0.cnt"}, 32'(c0), 32'd0);
    chk({tag, " u1.cnt"}, 32'(c1), 32'd0);
    chk({tag, " u2.cnt"}, 32'(c2), 32'd0);
    chk({tag, " u0.state"}, 32'(s0), 32'd0);
    chk({tag, " u1.state"}, 32'(s1), 32'd0);
    chk({tag, " u2.state"}, 32'(s2), 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    chk_zero("reset");
    #1 init = 1'b1;

    // Patterns: u0 = (10,00,11), u1/u2 = (01,01)
    step(1'b1, 6'b11_00_10, 4'b01_01, 4'b01_01, 1'b0, 1'b0, 2'b00);
    feed(2'b10); feed(2'b00); feed(2'b11);
    feed(2'b10); feed(2'b00); idle(); idle(); idle(); feed(2'b11);
    feed(2'b01); feed(2'b01); feed(2'b01);
    for (int r = 0; r < 10; r++) feed(2'b01);

    // Load mid-stream with a valid symbol present: the symbol is discarded
    feed(2'b10); feed(2'b00);
    step(1'b1, 6'b11_11_11, 4'b01_01, 4'b01_01, 1'b0, 1'b1, 2'b11);
    feed(2'b11); feed(2'b11); feed(2'b11); feed(2'b11);
    step(1'b0, pat0, pat1, pat2, 1'b1, 1'b1, 2'b11);
    feed(2'b11);

    for (int r = 0; r < 400; r++) begin
      logic pl, clr, v;
      pl  = ($urandom_range(0, 49) == 0);
      clr = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 9) < 7);
      step(pl, 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           clr, v, 2'($urandom_range(0, 3)));
    end

    // Build up some state, then reset asynchronously between edges
    step(1'b1, 6'b01_01_01, 4'b01_01, 4'b01_01, 1'b0, 1'b0, 2'b00);
    feed(2'b01); feed(2'b01); feed(2'b01);
    idle();
    @(negedge clock);
    #1 init = 1'b0;
    #1 chk_zero("async_reset");
    model_reset();
    #1 init = 1'b1;
    // Pattern is back to all zeros
    feed(2'b00); feed(2'b00); feed(2'b00); feed(2'b00);
    idle();

    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
